tile_pattern_generator: RTL and testbench

Parametrised test-pattern source for the video output path, successor to the fixed four-colour tile generator. Supplies one 24-bit RGB pixel per accepted transfer, walks a configurable H_ACTIVE x V_ACTIVE frame, and supports four run-time pattern modes from a writable four-entry palette. Sits in front of the video encoder/DVI path and is paced by the sink's VideoReady. It also supplies frame and line markers for downstream alignment and for the SIFT front end.

---
 rtl/tile_pattern_generator.sv | 125 ++++++++++++
 tb/tb_tile_pattern_generator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tile_pattern_generator.sv
// Parametrised tile/bar test-pattern source for the video output path.
// Walks an H_ACTIVE x V_ACTIVE frame paced by VideoReady, colouring pixels from a writable 4-entry palette.
module tile_pattern_generator #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int TILE_W   = 80,
    parameter int TILE_H   = 50
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VideoReady,
    input  logic [1:0]  Mode,
    input  logic        PaletteWe,
    input  logic [1:0]  PaletteAddr,
    input  logic [23:0] PaletteData,
    output logic [23:0] video,
    output logic        FrameStart,
    output logic        LineEnd,
    output logic        FrameEnd
);

    localparam int XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [PXW-1:0] PX_LAST = PXW'(TILE_W - 1);
    localparam logic [PYW-1:0] PY_LAST = PYW'(TILE_H - 1);

    // Entry [3] is leftmost: {46,204,113}, {241,196,15}, {230,126,34}, {26,188,156}
    localparam logic [3:0][23:0] PAL_RST = {24'h2ECC71, 24'hF1C40F, 24'hE67E22, 24'h1ABC9C};

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [PXW-1:0]    px_q, px_d;
    logic [PYW-1:0]    py_q, py_d;
    logic [1:0]        tcol_q, tcol_d;
    logic [1:0]        band_q, band_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0][23:0]  pal_q, pal_d;
    logic [1:0]        idx;

    assign FrameStart = (x_q == '0) && (y_q == '0);
    assign LineEnd    = (x_q == X_LAST);
    assign FrameEnd   = LineEnd && (y_q == Y_LAST);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        px_d   = px_q;
        py_d   = py_q;
        tcol_d = tcol_q;
        band_d = band_q;
        mode_d = mode_q;
        pal_d  = pal_q;
        // The pixel leaving on this edge was already coloured from pal_q, so the write only affects later pixels
        if (PaletteWe)
            pal_d[PaletteAddr] = PaletteData;
        if (VideoReady) begin
            if (LineEnd) begin
                x_d    = '0;
                px_d   = '0;
                tcol_d = '0;
                if (FrameEnd) begin
                    y_d    = '0;
                    py_d   = '0;
                    band_d = '0;
                    mode_d = Mode;
                end else begin
                    y_d = y_q + 1'b1;
                    if (py_q == PY_LAST) begin
                        py_d   = '0;
                        band_d = band_q + 1'b1;
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if (px_q == PX_LAST) begin
                    px_d   = '0;
                    tcol_d = tcol_q + 1'b1;
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            px_q   <= '0;
            py_q   <= '0;
            tcol_q <= '0;
            band_q <= '0;
            mode_q <= Mode;
            pal_q  <= PAL_RST;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            px_q   <= px_d;
            py_q   <= py_d;
            tcol_q <= tcol_d;
            band_q <= band_d;
            mode_q <= mode_d;
            pal_q  <= pal_d;
        end
    end

    always_comb begin
        case (mode_q)
            2'd0:    idx = {band_q[0], tcol_q[0]};
            2'd1:    idx = tcol_q;
            2'd2:    idx = band_q;
            default: idx = 2'd0;
        endcase
    end

    assign video = pal_q[idx];

endmodule

// File: tb/tb_tile_pattern_generator.sv
// Bench for tile_pattern_generator: scoreboard against a position model plus table-driven
// per-line colour checks on an 8x4 frame (TILE_W=2) and a partial-tile instance (TILE_W=3).
module tb_tile_pattern_generator;
    localparam int H = 8, V = 4, TW = 2, TH = 2;

    logic        Clock = 1'b0;
    logic        Reset, VideoReady, PaletteWe;
    logic [1:0]  Mode, PaletteAddr;
    logic [23:0] PaletteData;
    logic [23:0] video, video2;
    logic        FrameStart, LineEnd, FrameEnd, fs2, le2, fe2;

    tile_pattern_generator #(.H_ACTIVE(H), .V_ACTIVE(V), .TILE_W(TW), .TILE_H(TH)) dut (
        .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady), .Mode(Mode),
        .PaletteWe(PaletteWe), .PaletteAddr(PaletteAddr), .PaletteData(PaletteData),
        .video(video), .FrameStart(FrameStart), .LineEnd(LineEnd), .FrameEnd(FrameEnd));

    tile_pattern_generator #(.H_ACTIVE(H), .V_ACTIVE(V), .TILE_W(3), .TILE_H(TH)) dut3 (
        .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady), .Mode(Mode),
        .PaletteWe(PaletteWe), .PaletteAddr(PaletteAddr), .PaletteData(PaletteData),
        .video(video2), .FrameStart(fs2), .LineEnd(le2), .FrameEnd(fe2));

    always #5 Clock = ~Clock;

    typedef struct {
        int         which;  // 0: TILE_W=2 instance, 1: TILE_W=3 instance
        logic [1:0] mode;
        int         line;
        string      pat;    // expected palette index per pixel, pixel 0 first
    } vec_t;

    logic [23:0] PAL_DEF [4] = '{24'h1ABC9C, 24'hE67E22, 24'hF1C40F, 24'h2ECC71};

    vec_t        tbl[$];
    logic [26:0] expq[$];
    logic [23:0] stream_a[$], stream_b[$];
    int          rec_sel = 0;
    int          n_pass = 0, n_total = 0;

    int          mx, my;
    logic [1:0]  mmode;
    logic [23:0] mpal [4];

    task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (x=%0d y=%0d)", nm, got, exp, mx, my);
    endtask

    function automatic logic [26:0] exp_out();
        int tcol, band;
        logic [1:0] i;
        tcol = (mx / TW) % 4;
        band = (my / TH) % 4;
        case (mmode)
            2'd0:    i = 2'((band % 2) * 2 + (tcol % 2));
            2'd1:    i = 2'(tcol);
            2'd2:    i = 2'(band);
            default: i = 2'd0;
        endcase
        return {mpal[i], mx == 0 && my == 0, mx == H - 1, mx == H - 1 && my == V - 1};
    endfunction

    task automatic step(input bit rdy, input bit rst, input bit we, input logic [1:0] a, input logic [23:0] d);
        logic [26:0] pre, post, e;
        VideoReady = rdy; Reset = rst; PaletteWe = we; PaletteAddr = a; PaletteData = d;
        pre = {video, FrameStart, LineEnd, FrameEnd};
        if (rdy && !rst) begin
            if (rec_sel == 1) stream_a.push_back(video);
            else if (rec_sel == 2) stream_b.push_back(video);
        end
        if (rst) begin
            mx = 0; my = 0; mmode = Mode;
            for (int i = 0; i < 4; i++) mpal[i] = PAL_DEF[i];
        end else begin
            if (we) mpal[a] = d;
            if (rdy) begin
                if (mx == H - 1) begin
                    mx = 0;
                    if (my == V - 1) begin my = 0; mmode = Mode; end
                    else my++;
                end else mx++;
            end
        end
        expq.push_back(exp_out());
        @(posedge Clock); #1;
        e = expq.pop_front();
        post = {video, FrameStart, LineEnd, FrameEnd};
        chk("scoreboard", post, e);
        if (!rdy && !rst && !we) chk("hold", post, pre);
    endtask

    // One full frame with VideoReady=1; table rows for mode m are checked at every pixel
    task automatic run_frame(input logic [1:0] m, input int chg_at, input logic [1:0] new_mode);
        for (int p = 0; p < H * V; p++) begin
            if (p == chg_at) Mode = new_mode;
            foreach (tbl[r]) begin
                if (tbl[r].mode == m && tbl[r].line == p / H) begin
                    chk($sformatf("table_m%0d_d%0d", m, tbl[r].which),
                        27'(tbl[r].which ? video2 : video),
                        27'(PAL_DEF[int'(tbl[r].pat[p % H]) - 48]));
                end
            end
            step(1, 0, 0, 2'd0, 24'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{0, 2'd0, 0, "00110011"});
        tbl.push_back('{0, 2'd0, 1, "00110011"});
        tbl.push_back('{0, 2'd0, 2, "22332233"});
        tbl.push_back('{0, 2'd0, 3, "22332233"});
        for (int l = 0; l < 4; l++) tbl.push_back('{0, 2'd1, l, "00112233"});
        tbl.push_back('{0, 2'd2, 0, "00000000"});
        tbl.push_back('{0, 2'd2, 1, "00000000"});
        tbl.push_back('{0, 2'd2, 2, "11111111"});
        tbl.push_back('{0, 2'd2, 3, "11111111"});
        for (int l = 0; l < 4; l++) tbl.push_back('{0, 2'd3, l, "00000000"});
        tbl.push_back('{1, 2'd0, 0, "00011100"});
        tbl.push_back('{1, 2'd0, 1, "00011100"});

        Mode = 2'd0;
        step(0, 1, 0, 2'd0, 24'd0);
        step(1, 1, 1, 2'd3, 24'h000000);
        chk("reset_state", {video, FrameStart, LineEnd, FrameEnd}, {24'h1ABC9C, 3'b100});

        rec_sel = 1;
        run_frame(2'd0, -1, 2'd0);
        run_frame(2'd0, 5, 2'd1);   // mid-frame Mode change must not show until next frame
        rec_sel = 0;
        run_frame(2'd1, 3, 2'd2);
        run_frame(2'd2, 0, 2'd0);
        run_frame(2'd0, 10, 2'd3);
        run_frame(2'd3, 0, 2'd0);

        // Stalled stream over two frames must match the continuous stream
        step(0, 1, 0, 2'd0, 24'd0);
        rec_sel = 2;
        for (int c = 0; c < 2000 && stream_b.size() < 2 * H * V; c++)
            step(bit'($urandom_range(0, 1)), 0, 0, 2'd0, 24'd0);
        rec_sel = 0;
        chk("stream_len", 27'(stream_b.size()), 27'(stream_a.size()));
        for (int i = 0; i < stream_a.size() && i < stream_b.size(); i++)
            chk("stream_pixel", 27'(stream_b[i]), 27'(stream_a[i]));

        // Palette write while index 1 is presented
        step(0, 1, 0, 2'd0, 24'd0);
        step(1, 0, 0, 2'd0, 24'd0);
        step(1, 0, 0, 2'd0, 24'd0);
        chk("pal_before_write", 27'(video), 27'(PAL_DEF[1]));
        step(1, 0, 1, 2'd1, 24'hFF0000);
        chk("pal_after_write", 27'(video), 27'(24'hFF0000));

        // Advance to pixel 13, then reset with ready and a write pending
        for (int i = 0; i < 10; i++) step(1, 0, 0, 2'd0, 24'd0);
        chk("at_pixel13_pal", 27'(mx + my * H), 27'd13);
        step(1, 1, 1, 2'd0, 24'h123456);
        chk("reset_mid_frame", {video, FrameStart, LineEnd, FrameEnd}, {24'h1ABC9C, 3'b100});
        step(1, 0, 0, 2'd0, 24'd0);
        step(1, 0, 0, 2'd0, 24'd0);
        chk("pal_restored", 27'(video), 27'(PAL_DEF[1]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
